// File: rtl/astable_555_oscillator.sv
// rtl/astable_555_oscillator.sv - sample-rate NE555 astable oscillator with control-voltage input
//
// Ports:
//   clk      system clock
//   I_RSTn   asynchronous active-low reset
//   clk_en   one-cycle strobe at SAMPLE_RATE; all state advances only on it
//   enable   555 RESET pin; 0 holds the timer low and bleeds the capacitor
//   ctrl_en  1 = upper threshold taken from ctrl_v, 0 = internal 2/3 VCC divider
//   ctrl_v   signed control voltage (pin 5), clamped to [CTRL_MIN, CTRL_MAX]
//   out      HIGH_LEVEL while charging, 0 otherwise
//   cap_out  capacitor voltage, top SIGNAL_WIDTH bits of the internal state
//   toggle   one-clock pulse on every change of out
module astable_555_oscillator #(
  parameter int  SAMPLE_RATE  = 48000,
  parameter int  SIGNAL_WIDTH = 16,
  parameter real R1           = 10e3,
  parameter real R2           = 10e3,
  parameter real C            = 1e-6,
  parameter int  HIGH_LEVEL   = 22937,
  parameter int  CTRL_MIN     = 4096,
  parameter int  CTRL_MAX     = 28672
) (
  input  logic                           clk,
  input  logic                           I_RSTn,
  input  logic                           clk_en,
  input  logic                           enable,
  input  logic                           ctrl_en,
  input  logic signed [SIGNAL_WIDTH-1:0] ctrl_v,
  output logic signed [SIGNAL_WIDTH-1:0] out,
  output logic signed [SIGNAL_WIDTH-1:0] cap_out,
  output logic                           toggle
);

  localparam int W  = SIGNAL_WIDTH;
  localparam int VW = 2 * SIGNAL_WIDTH;
  localparam int KF = 24;

  // Per-sample RC coefficients, rounded to KF fraction bits.
  localparam logic [KF-1:0] K_CH  = KF'($rtoi(16777216.0 / (real'(SAMPLE_RATE) * C * (R1 + R2)) + 0.5));
  localparam logic [KF-1:0] K_DIS = KF'($rtoi(16777216.0 / (real'(SAMPLE_RATE) * C * R2) + 0.5));

  // V has VW-1 fraction bits, so V_ONE is exactly 1.0 and V_MAX the largest legal value.
  localparam logic [VW-1:0] V_ONE = {1'b1, {(VW-1){1'b0}}};
  localparam logic [VW-1:0] V_MAX = {1'b0, {(VW-1){1'b1}}};

  localparam logic [W-1:0]        DIV_UPPER = W'(((64'd1 << W) - 64'd1) / 64'd3);
  localparam logic signed [W-1:0] CTRL_LO   = W'(CTRL_MIN);
  localparam logic signed [W-1:0] CTRL_HI   = W'(CTRL_MAX);
  localparam logic signed [W-1:0] HIGH_OUT  = W'(HIGH_LEVEL);

  typedef enum logic [1:0] {
    HELD        = 2'd0,
    CHARGING    = 2'd1,
    DISCHARGING = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [VW-1:0]  v, v_next, v_ch, v_dis, dis_step;
  logic [VW:0]    ch_sum;
  logic [VW+KF-1:0] ch_prod, dis_prod;
  logic [W-1:0]   upper, lower, v_top_ch, v_top_dis;
  logic           high_next;

  // Candidate next capacitor voltages for both directions, products truncated.
  always_comb begin
    ch_prod   = {{KF{1'b0}}, V_ONE - v} * {{VW{1'b0}}, K_CH};
    ch_sum    = {1'b0, v} + {1'b0, VW'(ch_prod >> KF)};
    v_ch      = (ch_sum > {1'b0, V_MAX}) ? V_MAX : ch_sum[VW-1:0];
    dis_prod  = {{KF{1'b0}}, v} * {{VW{1'b0}}, K_DIS};
    dis_step  = VW'(dis_prod >> KF);
    v_dis     = (dis_step > v) ? '0 : v - dis_step;
    v_top_ch  = v_ch[VW-1 -: W];
    v_top_dis = v_dis[VW-1 -: W];
  end

  always_comb begin
    upper = DIV_UPPER;
    if (ctrl_en) begin
      if (ctrl_v < CTRL_LO)      upper = CTRL_LO;
      else if (ctrl_v > CTRL_HI) upper = CTRL_HI;
      else                       upper = ctrl_v;
    end
    lower = upper >> 1;
  end

  // Thresholds are tested against the freshly computed voltage, so a threshold
  // moved past the current voltage is acted on at the very next strobe.
  always_comb begin
    state_next = state;
    v_next     = v;
    if (clk_en) begin
      if (!enable) begin
        state_next = HELD;
        v_next     = v_dis;
      end else begin
        case (state)
          HELD: begin
            v_next     = v_dis;
            state_next = CHARGING;
          end
          CHARGING: begin
            v_next = v_ch;
            if (v_top_ch >= upper) state_next = DISCHARGING;
          end
          DISCHARGING: begin
            v_next = v_dis;
            if (v_top_dis <= lower) state_next = CHARGING;
          end
          default: begin
            v_next     = v_dis;
            state_next = HELD;
          end
        endcase
      end
    end
    high_next = (state_next == CHARGING);
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state  <= HELD;
      v      <= '0;
      toggle <= 1'b0;
    end else begin
      state  <= state_next;
      v      <= v_next;
      toggle <= high_next ^ (state == CHARGING);
    end
  end

  assign out     = (state == CHARGING) ? HIGH_OUT : '0;
  assign cap_out = {1'b0, v[VW-2 -: W-1]};

endmodule

// File: tb/tb_astable_555_oscillator.sv
// tb/tb_astable_555_oscillator.sv - randomized self-checking bench for astable_555_oscillator
module tb_astable_555_oscillator;

  localparam longint HIGH = 22937;
  localparam longint ONE  = 64'd2147483648;
  localparam longint KSC  = 64'd16777216;
  localparam longint KCH  = $rtoi(16777216.0 / (48000.0 * 1e-6 * 20000.0) + 0.5);
  localparam longint KDIS = $rtoi(16777216.0 / (48000.0 * 1e-6 * 10000.0) + 0.5);

  logic clk = 1'b0;
  logic I_RSTn, clk_en, enable, ctrl_en;
  logic signed [15:0] ctrl_v;
  logic signed [15:0] out, cap_out;
  logic toggle;

  int n_chk = 0;
  int n_err = 0;

  longint mv = 0;
  bit m_held = 1'b1;
  bit m_high = 1'b0;
  bit exp_tog = 1'b0;

  int seg = 0;
  int ntrans = 0;
  int last_len = 0;
  int first_len = 0;
  logic signed [15:0] prev_out = '0;

  astable_555_oscillator dut (
    .clk     (clk),
    .I_RSTn  (I_RSTn),
    .clk_en  (clk_en),
    .enable  (enable),
    .ctrl_en (ctrl_en),
    .ctrl_v  (ctrl_v),
    .out     (out),
    .cap_out (cap_out),
    .toggle  (toggle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint charge(input longint x);
    longint y;
    y = x + (KCH * (ONE - x)) / KSC;
    if (y > ONE - 1) y = ONE - 1;
    return y;
  endfunction

  function automatic longint disch(input longint x);
    longint y;
    y = x - (KDIS * x) / KSC;
    if (y < 0) y = 0;
    return y;
  endfunction

  // Behavioural 555: capacitor charges toward VCC while the output is high and
  // bleeds toward ground otherwise; comparator levels follow pin 5.
  task automatic model_update(input bit en, input bit cen, input int cv);
    longint up, lo;
    if (cen) up = (cv < 4096) ? 4096 : ((cv > 28672) ? 28672 : cv);
    else     up = 21845;
    lo = up / 2;
    if (!en) begin
      mv = disch(mv); m_held = 1'b1; m_high = 1'b0;
    end else if (m_held) begin
      mv = disch(mv); m_held = 1'b0; m_high = 1'b1;
    end else if (m_high) begin
      mv = charge(mv);
      if (mv / 65536 >= up) m_high = 1'b0;
    end else begin
      mv = disch(mv);
      if (mv / 65536 <= lo) m_high = 1'b1;
    end
  endtask

  // One clock: inputs are already set (at the falling edge); outputs checked #1 after the rise.
  task automatic cyc(input bit s);
    bit was_high;
    int cv;
    clk_en = s;
    @(posedge clk);
    was_high = m_high;
    cv = $signed(ctrl_v);
    if (!I_RSTn) begin
      mv = 0; m_held = 1'b1; m_high = 1'b0;
    end else if (s) begin
      model_update(enable, ctrl_en, cv);
    end
    exp_tog = I_RSTn && (m_high != was_high);
    #1;
    chk("out", out, m_high ? HIGH : 0);
    chk("cap_out", cap_out, mv / 65536);
    chk("toggle", toggle, exp_tog);
    if (s) begin
      seg++;
      if (out !== prev_out) begin
        last_len = seg;
        seg = 0;
        ntrans++;
        prev_out = out;
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_trans(input int gap, output int len);
    int start;
    int k;
    start = ntrans;
    k = 0;
    while (ntrans == start && k < 4000) begin
      repeat (gap) cyc(1'b0);
      cyc(1'b1);
      k++;
    end
    chk("wait_bound", ntrans != start, 1);
    len = last_len;
  endtask

  task automatic measure(input int gap, output int hi, output int lo);
    int l;
    int k;
    k = 0;
    wait_trans(gap, l);
    while (out !== 16'sd0 && k < 3) begin
      wait_trans(gap, l);
      k++;
    end
    wait_trans(gap, lo);
    wait_trans(gap, hi);
  endtask

  task automatic do_reset();
    #2 I_RSTn = 1'b0;
    #1;
    mv = 0; m_held = 1'b1; m_high = 1'b0;
    chk("async_rst_out", out, 0);
    chk("async_rst_cap", cap_out, 0);
    chk("async_rst_toggle", toggle, 0);
    prev_out = '0;
    seg = 0;
    cyc(1'b0);
    cyc(1'b0);
    I_RSTn = 1'b1;
  endtask

  function automatic bit near(input int v, input int nom, input int tol);
    return (v >= nom - tol) && (v <= nom + tol);
  endfunction

  initial begin
    int len, hi, lo, hi_ref, lo_ref, k;
    logic signed [15:0] prev_cap;

    I_RSTn = 1'b0; clk_en = 1'b0; enable = 1'b1; ctrl_en = 1'b0;
    ctrl_v = 16'($urandom);
    @(negedge clk);
    chk("reset_out", out, 0);
    chk("reset_cap", cap_out, 0);
    chk("reset_toggle", toggle, 0);
    cyc(1'b0);
    I_RSTn = 1'b1;

    // Free-running default thresholds.
    wait_trans(0, len);
    wait_trans(0, len); first_len = len;
    chk($sformatf("first_high(len=%0d)", len), near(len, 1055, 2), 1);
    for (int i = 0; i < 2; i++) begin
      wait_trans(0, len);
      chk($sformatf("low_time(len=%0d)", len), near(len, 333, 2), 1);
      wait_trans(0, len);
      chk($sformatf("high_time(len=%0d)", len), near(len, 665, 2), 1);
    end

    // Control voltage at half VCC.
    ctrl_en = 1'b1; ctrl_v = 16'sd16384;
    measure(0, hi, lo);
    measure(0, hi, lo);
    chk($sformatf("ctrl_high(len=%0d)", hi), near(hi, 389, 2), 1);
    chk($sformatf("ctrl_low(len=%0d)", lo), near(lo, 333, 2), 1);

    // Clamping: out-of-range control voltages behave as the clamp limits.
    ctrl_v = 16'sd28672;
    measure(0, hi_ref, lo_ref); measure(0, hi_ref, lo_ref);
    ctrl_v = 16'sd32767;
    measure(0, hi, lo); measure(0, hi, lo);
    chk($sformatf("clamp_hi_high(%0d vs %0d)", hi, hi_ref), near(hi, hi_ref, 1), 1);
    chk($sformatf("clamp_hi_low(%0d vs %0d)", lo, lo_ref), near(lo, lo_ref, 1), 1);
    ctrl_v = 16'sd4096;
    measure(0, hi_ref, lo_ref); measure(0, hi_ref, lo_ref);
    ctrl_v = -16'sd5;
    measure(0, hi, lo); measure(0, hi, lo);
    chk($sformatf("clamp_lo_high(%0d vs %0d)", hi, hi_ref), near(hi, hi_ref, 1), 1);
    chk($sformatf("clamp_lo_low(%0d vs %0d)", lo, lo_ref), near(lo, lo_ref, 1), 1);

    // enable dropped mid-high, then restored.
    ctrl_en = 1'b0;
    measure(0, hi, lo);
    wait_trans(0, len);
    repeat (50) cyc(1'b1);
    chk("pre_disable_out", out, HIGH);
    enable = 1'b0;
    cyc(1'b1);
    chk("disable_out", out, 0);
    chk("disable_toggle", toggle, 1);
    for (int i = 0; i < 60; i++) begin
      prev_cap = cap_out;
      cyc(1'b1);
      chk("decay", cap_out <= prev_cap, 1);
    end
    enable = 1'b1;
    cyc(1'b1);
    chk("reenable_out", out, HIGH);

    // Asynchronous reset while discharging.
    wait_trans(0, len);
    repeat (20) cyc(1'b1);
    chk("pre_reset_cap_nonzero", cap_out > 0, 1);
    do_reset();
    wait_trans(0, len);
    wait_trans(0, len);
    chk($sformatf("rst_first_high(len=%0d)", len), near(len, 1055, 2), 1);

    // Strobe on every third clock.
    do_reset();
    wait_trans(2, len);
    wait_trans(2, len);
    chk("gap_first_high", len, first_len);
    wait_trans(2, len);
    chk($sformatf("gap_low(len=%0d)", len), near(len, 333, 2), 1);

    // Threshold stepped below the capacitor voltage while charging.
    ctrl_en = 1'b1; ctrl_v = 16'sd28672;
    do_reset();
    k = 0;
    while (cap_out < 16'sd20000 && k < 3000) begin cyc(1'b1); k++; end
    chk("step_pre_high", out, HIGH);
    ctrl_v = 16'sd8192;
    cyc(1'b1);
    chk("step_discharge", out, 0);
    k = 0;
    prev_cap = cap_out;
    while (out == 16'sd0 && k < 3000) begin prev_cap = cap_out; cyc(1'b1); k++; end
    chk("step_recharge", out, HIGH);
    chk($sformatf("step_low_cap(%0d)", cap_out), cap_out <= 16'sd4096, 1);
    chk($sformatf("step_prev_cap(%0d)", prev_cap), prev_cap > 16'sd4096, 1);

    // Randomized strobes, thresholds and enable against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) ctrl_en = ~ctrl_en;
      if ($urandom_range(0, 99) == 0)  ctrl_v = 16'($urandom);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/astable_555_oscillator.md
# astable_555_oscillator

Sample-rate model of an NE555 wired as an astable multivibrator with optional control-voltage (pin 5) modulation. It is the source stage of the discrete sound chain. `out` drives one `in[]` input of the downstream RC low-pass filter. `cap_out` can modulate another oscillator's control input. All voltages are signed fixed-point normalised to VCC: +2^(SIGNAL_WIDTH-1) corresponds to VCC.

## Interface
- `SAMPLE_RATE`, 48000, update rate of `clk_en` [Hz]
- `SIGNAL_WIDTH`, 16, width of all signal ports
- `R1`, 10e3, VCC-to-discharge resistor [Ohm]
- `R2`, 10e3, discharge-to-threshold resistor [Ohm]
- `C`, 1e-6, timing capacitor [F]
- `HIGH_LEVEL`, 22937, value of `out` while the output is high (≈0.7·VCC)
- `CTRL_MIN`, 4096, lower clamp on `ctrl_v` (VCC/8)
- `CTRL_MAX`, 28672, upper clamp on `ctrl_v` (7·VCC/8)

Ports:
- `clk` input 1: system clock
- `I_RSTn` input 1: reset; one clock; reset is asynchronous and active-low
- `clk_en` input 1: one-cycle strobe at `SAMPLE_RATE`
- `enable` input 1: models the 555 RESET pin; 0 = held in reset
- `ctrl_en` input 1: 1 = use `ctrl_v` as the threshold; 0 = internal 2/3·VCC divider
- `ctrl_v` input signed[SIGNAL_WIDTH] control voltage
- `out` output signed[SIGNAL_WIDTH]: `HIGH_LEVEL` or 0
- `cap_out` output signed[SIGNAL_WIDTH]: capacitor voltage, always ≥ 0
- `toggle` output 1: one-clock pulse on each output transition

## Operation
- State: `V` is the unsigned capacitor voltage, 2·SIGNAL_WIDTH bits with 2·SIGNAL_WIDTH−1 fraction bits, range [0,1). Coefficients are quantised at elaboration to 24 fraction bits:
  - `K_CH = 1/(SAMPLE_RATE·C·(R1+R2))`
  - `K_DIS = 1/(SAMPLE_RATE·C·R2)`
- Thresholds:
  - `UPPER` = clamp(`ctrl_v`, `CTRL_MIN`, `CTRL_MAX`) when `ctrl_en`=1, else 21845.
  - `LOWER` = `UPPER`>>1.
  - Thresholds are compared against `V` at SIGNAL_WIDTH precision (top bits). They are sampled on the same `clk_en` that uses them.
- FSM states: HELD, CHARGING, DISCHARGING.
  - **HELD**: `V_next = V − K_DIS·V`, output low. On `clk_en` with `enable`=1, go to CHARGING.
  - **CHARGING**: `V_next = V + K_CH·(1−V)`. If `V_next ≥ UPPER`, go to DISCHARGING.
  - **DISCHARGING**: `V_next = V − K_DIS·V`. If `V_next ≤ LOWER`, go to CHARGING.
  - In any state, `enable`=0 at `clk_en` sends the FSM to HELD. This takes priority over threshold crossings.
- Arithmetic:
  - Products are truncated toward zero.
  - `V` saturates to [0, 1−2^-(2W−1)] and never wraps.
  - If `UPPER` or `LOWER` changes so that a threshold is already crossed, the transition occurs on the next `clk_en`. Exactly one transition is allowed per `clk_en`.
- Outputs:
  - `out` = `HIGH_LEVEL` in CHARGING, 0 otherwise.
  - `cap_out` = top SIGNAL_WIDTH bits of `V` with the sign bit 0.
  - `toggle` = 1 for exactly the clock in which `out` changes value.

## Timing
- Reset asserted: `V`=0, state HELD, `out`=0, `cap_out`=0, `toggle`=0. This takes effect immediately and asynchronously, including mid-cycle.
- Nothing changes on clocks without `clk_en`.
- All outputs are registered and update on the `clk` edge where `clk_en`=1, so latency is one clock from the strobe.
- `V_next` and the new state are committed on the same edge.
- `enable` and `ctrl_*` are sampled only on `clk_en`.
- Back-to-back `clk_en` on consecutive clocks is legal; each strobe is one full update.
- Nominal periods:
  - High time = 0.693·(R1+R2)·C.
  - Low time = 0.693·R2·C.
  - The first high period from `V`=0 is 1.0986·(R1+R2)·C.

## Test plan
- Defaults, `enable`=1, `ctrl_en`=0, `clk_en` every clock: first high period 1055±2 strobes; then high 665±2 / low 333±2 strobes, repeating. `toggle` pulses once per edge.
- `ctrl_en`=1, `ctrl_v`=16384 after settling: high 389±2, low 333±2 strobes. `ctrl_v`=32767 clamps to 28672; `ctrl_v`=−5 clamps to 4096.
- `enable`→0 mid-high: on the next strobe `out`=0 and `toggle` pulses, then `cap_out` decays monotonically. `enable`→1: `out`=`HIGH_LEVEL` on the next strobe.
- Assert `I_RSTn`=0 between strobes mid-discharge: all outputs go to 0 without waiting for a clock edge. After release, the first-period timing of 1055±2 repeats.
- `clk_en` every 3rd clock: outputs change only on strobe clocks, and the period in strobes is identical to the first case.
- Step `ctrl_v` from 28672 to 8192 while charging with `cap_out`≈20000: on the next strobe the FSM moves to DISCHARGING. It stays there until `cap_out` ≤ 4096.
